// File: rtl/rate_controller.sv
// rate_controller: debounces the front-panel buttons and steps the clock divider's rate select.
// Latency: raw press edge to change_pulse = 2 + DEBOUNCE_CYCLES + 1 + 1 clk cycles; all outputs registered.
// Backpressure: none; up/down presses seen while busy are dropped, pause is honoured in every state.
// Ports: clk, rst (async active-high); btn_up/btn_down/btn_pause raw asynchronous buttons;
//        div_sel/rate_idx divider select; run downstream gate; busy settle window; change_pulse strobe.
module rate_controller #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SETTLE_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_pause,
   output logic [2:0] div_sel,
   output logic [1:0] rate_idx,
   output logic       run,
   output logic       busy,
   output logic       change_pulse
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   // A single settle cycle still needs a one-bit counter.
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   // Button lane indices inside the conditioning vectors.
   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_PAUSE = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   logic [2:0]    btn_raw;
   logic [2:0]    sync1_q;
   logic [2:0]    sync2_q;
   logic [2:0]    deb_q;
   logic [2:0]    deb_d;
   logic [2:0]    deb_dly_q;
   logic [2:0]    press_q;
   logic [DW-1:0] cnt_q [3];
   logic [DW-1:0] cnt_d [3];

   state_t        state_q;
   logic [1:0]    rate_q;
   logic          run_q;
   logic          busy_q;
   logic          change_pulse_q;
   logic [SW-1:0] settle_cnt_q;

   assign btn_raw = {btn_pause, btn_down, btn_up};

   // Debounce: the synchronized level must differ from the debounced state for
   // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts the count.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i] + 1'b1;
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEB_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         press_q   <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         // Registered rising-edge detect: one pulse per debounced press, none on release.
         press_q   <= deb_q & ~deb_dly_q;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         rate_q         <= 2'd0;
         run_q          <= 1'b0;
         busy_q         <= 1'b0;
         change_pulse_q <= 1'b0;
         settle_cnt_q   <= '0;
      end else begin
         // Pause is independent of the rate sequencer.
         if (press_q[B_PAUSE]) begin
            run_q <= ~run_q;
         end
         case (state_q)
            ST_IDLE: begin
               change_pulse_q <= 1'b0;
               busy_q         <= 1'b0;
               // Simultaneous up and down cancel each other; saturation leaves the rate untouched.
               if (press_q[B_UP] && !press_q[B_DOWN] && (rate_q != 2'd3)) begin
                  rate_q         <= rate_q + 2'd1;
                  change_pulse_q <= 1'b1;
                  busy_q         <= 1'b1;
                  state_q        <= ST_APPLY;
               end else if (press_q[B_DOWN] && !press_q[B_UP] && (rate_q != 2'd0)) begin
                  rate_q         <= rate_q - 2'd1;
                  change_pulse_q <= 1'b1;
                  busy_q         <= 1'b1;
                  state_q        <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               change_pulse_q <= 1'b0;
               settle_cnt_q   <= '0;
               state_q        <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  busy_q       <= 1'b0;
                  settle_cnt_q <= '0;
                  state_q      <= ST_IDLE;
               end else begin
                  settle_cnt_q <= settle_cnt_q + 1'b1;
               end
            end
            default: begin
               change_pulse_q <= 1'b0;
               busy_q         <= 1'b0;
               state_q        <= ST_IDLE;
            end
         endcase
      end
   end

   assign rate_idx     = rate_q;
   assign div_sel      = {1'b0, rate_q};
   assign run          = run_q;
   assign busy         = busy_q;
   assign change_pulse = change_pulse_q;

endmodule

// File: tb/tb_rate_controller.sv
// tb_rate_controller: directed checks of rate_controller with DEBOUNCE_CYCLES=4, SETTLE_CYCLES=3.
// Latency: a press raised just after edge k is expected to strobe change_pulse after edge k+8.
// Backpressure: none; the bench only drives buttons and reset.
module tb_rate_controller;

   logic       clk;
   logic       rst;
   logic       btn_up;
   logic       btn_down;
   logic       btn_pause;
   logic [2:0] div_sel;
   logic [1:0] rate_idx;
   logic       run;
   logic       busy;
   logic       change_pulse;

   int n_checks  = 0;
   int n_fail    = 0;
   int pulse_cnt = 0;
   int busy_cnt  = 0;

   rate_controller #(
      .DEBOUNCE_CYCLES (4),
      .SETTLE_CYCLES   (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_up       (btn_up),
      .btn_down     (btn_down),
      .btn_pause    (btn_pause),
      .div_sel      (div_sel),
      .rate_idx     (rate_idx),
      .run          (run),
      .busy         (busy),
      .change_pulse (change_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counts of strobe and busy, sampled on the falling edge.
   always @(negedge clk) begin
      if (change_pulse === 1'b1) pulse_cnt++;
      if (busy === 1'b1) busy_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold {pause, down, up} long enough to debounce, settle, and debounce the release.
   task automatic press(input logic [2:0] b);
      {btn_pause, btn_down, btn_up} = b;
      tick(12);
      {btn_pause, btn_down, btn_up} = 3'b000;
      tick(12);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      {btn_pause, btn_down, btn_up} = 3'b000;
      tick(3);
      n_checks++;
      if ({rate_idx, div_sel, run, busy, change_pulse} !== 8'b00_000_0_0_0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 00000000", {rate_idx, div_sel, run, busy, change_pulse});
      end
      rst = 1'b0;
      pulse_cnt = 0;
      busy_cnt  = 0;
      tick(20);
      n_checks++;
      if ({rate_idx, div_sel, run, busy} !== 7'b00_000_0_0) begin
         n_fail++;
         $display("FAIL idle_outputs: got %b expected 0000000", {rate_idx, div_sel, run, busy});
      end
      n_checks++;
      if (pulse_cnt !== 0) begin
         n_fail++;
         $display("FAIL idle_pulses: got %0d expected 0", pulse_cnt);
      end
   endtask

   task automatic test_single_up();
      pulse_cnt = 0;
      busy_cnt  = 0;
      btn_up = 1'b1;
      tick(7);
      n_checks++;
      if (pulse_cnt !== 0 || change_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL up_early: got pulses=%0d strobe=%b expected 0 0", pulse_cnt, change_pulse);
      end
      tick(1);
      n_checks++;
      if ({change_pulse, busy, div_sel} !== 5'b1_1_001) begin
         n_fail++;
         $display("FAIL up_latency8: got %b expected 11001", {change_pulse, busy, div_sel});
      end
      tick(12);
      n_checks++;
      if (pulse_cnt !== 1) begin
         n_fail++;
         $display("FAIL up_pulse_count: got %0d expected 1", pulse_cnt);
      end
      n_checks++;
      if (busy_cnt !== 4) begin
         n_fail++;
         $display("FAIL up_busy_len: got %0d expected 4", busy_cnt);
      end
      n_checks++;
      if ({div_sel, rate_idx, busy} !== 6'b001_01_0) begin
         n_fail++;
         $display("FAIL up_final: got %b expected 001010", {div_sel, rate_idx, busy});
      end
      btn_up = 1'b0;
      tick(12);
   endtask

   task automatic test_bounce_saturate();
      pulse_cnt = 0;
      btn_up = 1'b1; tick(2);
      btn_up = 1'b0; tick(2);
      btn_up = 1'b1; tick(2);
      btn_up = 1'b0; tick(2);
      btn_up = 1'b1;
      tick(7);
      n_checks++;
      if (pulse_cnt !== 0 || rate_idx !== 2'd1) begin
         n_fail++;
         $display("FAIL bounce_quiet: got pulses=%0d rate=%0d expected 0 1", pulse_cnt, rate_idx);
      end
      tick(1);
      n_checks++;
      if ({change_pulse, rate_idx} !== 3'b1_10) begin
         n_fail++;
         $display("FAIL bounce_step: got %b expected 110", {change_pulse, rate_idx});
      end
      tick(12);
      btn_up = 1'b0;
      tick(12);
      press(3'b001);
      n_checks++;
      if ({rate_idx, div_sel} !== 5'b11_011) begin
         n_fail++;
         $display("FAIL up_to_max: got %b expected 11011", {rate_idx, div_sel});
      end
      pulse_cnt = 0;
      press(3'b001);
      n_checks++;
      if (pulse_cnt !== 0 || div_sel !== 3'b011) begin
         n_fail++;
         $display("FAIL sat_high: got pulses=%0d div_sel=%b expected 0 011", pulse_cnt, div_sel);
      end
      pulse_cnt = 0;
      press(3'b010);
      press(3'b010);
      press(3'b010);
      n_checks++;
      if (pulse_cnt !== 3 || div_sel !== 3'b000) begin
         n_fail++;
         $display("FAIL down_to_min: got pulses=%0d div_sel=%b expected 3 000", pulse_cnt, div_sel);
      end
      pulse_cnt = 0;
      press(3'b010);
      n_checks++;
      if (pulse_cnt !== 0 || {rate_idx, div_sel} !== 5'b00_000) begin
         n_fail++;
         $display("FAIL sat_low: got pulses=%0d sel=%b expected 0 00000", pulse_cnt, {rate_idx, div_sel});
      end
   endtask

   task automatic test_simultaneous();
      pulse_cnt = 0;
      busy_cnt  = 0;
      press(3'b011);
      n_checks++;
      if (pulse_cnt !== 0 || busy_cnt !== 0 || rate_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL up_down_same: got pulses=%0d busy=%0d rate=%0d expected 0 0 0", pulse_cnt, busy_cnt, rate_idx);
      end
      press(3'b100);
      n_checks++;
      if (run !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_on: got %b expected 1", run);
      end
      press(3'b100);
      n_checks++;
      if (run !== 1'b0 || busy_cnt !== 0 || pulse_cnt !== 0) begin
         n_fail++;
         $display("FAIL pause_off: got run=%b busy=%0d pulses=%0d expected 0 0 0", run, busy_cnt, pulse_cnt);
      end
   endtask

   // Up accepted at edge 8; down debounces into SETTLE at edge 10 and is dropped;
   // pause lands at edge 11 while busy is still high.
   task automatic test_drop_during_settle();
      pulse_cnt = 0;
      busy_cnt  = 0;
      btn_up = 1'b1;
      tick(2);
      btn_down = 1'b1;
      tick(1);
      btn_pause = 1'b1;
      tick(5);
      n_checks++;
      if ({change_pulse, rate_idx} !== 3'b1_01) begin
         n_fail++;
         $display("FAIL drop_first: got %b expected 101", {change_pulse, rate_idx});
      end
      tick(2);
      n_checks++;
      if ({run, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL drop_pre_pause: got %b expected 01", {run, busy});
      end
      tick(1);
      n_checks++;
      if ({run, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL pause_in_settle: got %b expected 11", {run, busy});
      end
      tick(1);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL settle_end: got %b expected 0", busy);
      end
      {btn_pause, btn_down, btn_up} = 3'b000;
      tick(14);
      n_checks++;
      if (pulse_cnt !== 1 || busy_cnt !== 4 || {rate_idx, run} !== 3'b01_1) begin
         n_fail++;
         $display("FAIL drop_final: got pulses=%0d busy=%0d rate_run=%b expected 1 4 011", pulse_cnt, busy_cnt, {rate_idx, run});
      end
   endtask

   task automatic test_reset_mid_settle();
      btn_up = 1'b1;
      tick(9);
      n_checks++;
      if ({rate_idx, busy, run} !== 4'b10_1_1) begin
         n_fail++;
         $display("FAIL pre_reset: got %b expected 1011", {rate_idx, busy, run});
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({rate_idx, div_sel, run, busy, change_pulse} !== 8'b00_000_0_0_0) begin
         n_fail++;
         $display("FAIL async_reset: got %b expected 00000000", {rate_idx, div_sel, run, busy, change_pulse});
      end
      btn_up = 1'b0;
      tick(3);
      #2;
      rst = 1'b0;
      tick(3);
      pulse_cnt = 0;
      press(3'b001);
      n_checks++;
      if (pulse_cnt !== 1 || {div_sel, run, busy} !== 5'b001_0_0) begin
         n_fail++;
         $display("FAIL post_reset_up: got pulses=%0d out=%b expected 1 00100", pulse_cnt, {div_sel, run, busy});
      end
   endtask

   initial begin
      test_reset();
      test_single_up();
      test_bounce_saturate();
      test_simultaneous();
      test_drop_during_settle();
      test_reset_mid_settle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
